mc_path_scheduler: RTL and testbench
====================================

// Module: mc_path_scheduler
// PURPOSE
//   Sequences the Monte Carlo datapath of the Heston pricer: path_generator -> correlated_noise -> sde_solver.
//   Runs n_steps Euler steps per path, then payoff_calculator and one accumulator update.
//   After n_paths paths it runs discount_engine and raises done.
//   Sits between the top-level start/done handshake and the per-stage enable ports of heston_engine.
// PARAMETERS
//   LAT_PG    1   cycles en_pg is held per step (path_generator latency)
//   LAT_CORR  1   cycles en_corr is held per step (correlated_noise latency)
//   LAT_SDE   1   cycles en_sde is held per step (sde_solver latency)
//   LAT_PAY   1   cycles en_pay is held per path (payoff_calculator latency)
//   LAT_DISC  4   cycles en_disc is held per run (discount_engine latency)
//   STEP_W    16  width of step counter / n_steps
//   PATH_W    32  width of path counter / n_paths
// PORTS
//   clk        in   1       clock, all state on rising edge
//   rst        in   1       reset, asynchronous, active-low
//   start      in   1       run request, sampled only in IDLE
//   abort      in   1       cancel run, any state
//   n_steps    in   STEP_W  Euler steps per path (T/dt), captured at start
//   n_paths    in   PATH_W  paths per run, captured at start
//   en_pg      out  1       path_generator enable
//   en_corr    out  1       correlated_noise enable
//   en_sde     out  1       sde_solver enable
//   sel_init   out  1       1: sde_solver takes S0/v0; 0: takes fed-back S/v
//   en_pay     out  1       payoff_calculator enable
//   en_acc     out  1       accumulator enable (one cycle per path)
//   acc_clr    out  1       clear accumulator sum/count
//   en_disc    out  1       discount_engine enable
//   step_idx   out  STEP_W  current step within path, 0-based
//   path_idx   out  PATH_W  current path, 0-based
//   busy       out  1       high in every state except IDLE
//   done       out  1       one-cycle pulse: price valid
//   err        out  1       one-cycle pulse with done when n_steps or n_paths is 0
// BEHAVIOUR
//   - All outputs are registered, decoded from the next state; no combinational path from inputs to outputs.
//   - Reset: state=IDLE. All enables, acc_clr, busy, done and err are 0. step_idx and path_idx are 0.
//   - States: IDLE, GEN, CORR, SDE, PAY, ACC, DISC, DONE.
//   - A phase counter holds each timed state for its LAT_x cycles. ACC and DONE each last 1 cycle.
//   - IDLE: start=1 captures n_steps and n_paths. If either is 0, next state is DONE with err=1.
//     Otherwise next state is GEN, with step_idx=0, path_idx=0 and acc_clr=1 for that first GEN cycle.
//   - GEN -> CORR -> SDE. Exactly one of en_pg, en_corr, en_sde is high, matching the state.
//   - SDE exit: if step_idx < n_steps-1, step_idx++ and go to GEN. Otherwise go to PAY.
//   - sel_init=1 throughout GEN/CORR/SDE while step_idx==0, otherwise 0.
//   - PAY -> ACC. en_acc is high for exactly 1 cycle per path.
//   - ACC exit: if path_idx < n_paths-1, path_idx++, step_idx=0 and go to GEN. Otherwise go to DISC.
//   - DISC (en_disc high) -> DONE. DONE asserts done=1 for 1 cycle, then returns to IDLE.
//   - step_idx and path_idx keep their final values in IDLE until the next accepted start.
//   - Run latency: done rises N = n_paths*(n_steps*(LAT_PG+LAT_CORR+LAT_SDE) + LAT_PAY + 1) + LAT_DISC + 1
//     cycles after the start-sampling edge.
//   - start while busy: ignored. It is not queued.
//   - abort=1 in any non-IDLE state: next state is IDLE, all enables drop, and no done is issued.
//   - abort has priority over every transition. abort in IDLE with start=1: start is ignored.
//   - Asynchronous reset mid-run: immediate return to reset values. No done is issued.
//   - Counters never wrap. n_steps=2^STEP_W-1 and n_paths=2^PATH_W-1 are legal and are compared with no overflow.
// TESTING
//   - Defaults, n_steps=3, n_paths=2, start pulse:
//     -> done high exactly 27 cycles after the start edge;
//     -> en_acc high twice, en_disc high 4 cycles, acc_clr high once on the first GEN cycle.
//   - n_steps=1, n_paths=1:
//     -> sel_init high in GEN/CORR/SDE;
//     -> enable sequence pg, corr, sde, pay, acc, disc x4, then done 10 cycles after start.
//   - LAT_SDE=3, n_steps=2, n_paths=1:
//     -> en_sde held 3 consecutive cycles per step;
//     -> sel_init high only for step 0;
//     -> done at cycle 1*(2*5+2)+4+1=17.
//   - n_paths=0, start:
//     -> done=err=1 on the next cycle;
//     -> no enable, acc_clr or en_disc is ever asserted.
//   - abort during the second path's SDE phase:
//     -> IDLE next cycle, all enables 0, busy 0, no done;
//     -> a following start runs a full-length run with acc_clr asserted.
//   - Start pulse while busy, plus rst=0 mid-DISC:
//     -> the mid-run start changes no counter;
//     -> reset clears all outputs immediately, with no done.

Source files
------------

// File: rtl/mc_path_scheduler.sv
// Sequences the Monte Carlo datapath: per step pg -> corr -> sde, per path pay -> acc,
// then one discount pass and a done pulse. All outputs are registered from the next state.
//
// state  | meaning
// S_IDLE | waiting for start; indices hold their last values
// S_GEN  | path_generator enabled
// S_CORR | correlated_noise enabled
// S_SDE  | sde_solver enabled (one Euler step)
// S_PAY  | payoff_calculator enabled
// S_ACC  | accumulator update, one cycle per path
// S_DISC | discount_engine enabled
// S_DONE | done pulse (with err when a count was zero)
module mc_path_scheduler #(
  parameter int LAT_PG   = 1,
  parameter int LAT_CORR = 1,
  parameter int LAT_SDE  = 1,
  parameter int LAT_PAY  = 1,
  parameter int LAT_DISC = 4,
  parameter int STEP_W   = 16,
  parameter int PATH_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [STEP_W-1:0] n_steps,
  input  logic [PATH_W-1:0] n_paths,
  output logic              en_pg,
  output logic              en_corr,
  output logic              en_sde,
  output logic              sel_init,
  output logic              en_pay,
  output logic              en_acc,
  output logic              acc_clr,
  output logic              en_disc,
  output logic [STEP_W-1:0] step_idx,
  output logic [PATH_W-1:0] path_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int PH_W = 8;
  localparam logic [PH_W-1:0] LD_PG   = PH_W'(LAT_PG - 1);
  localparam logic [PH_W-1:0] LD_CORR = PH_W'(LAT_CORR - 1);
  localparam logic [PH_W-1:0] LD_SDE  = PH_W'(LAT_SDE - 1);
  localparam logic [PH_W-1:0] LD_PAY  = PH_W'(LAT_PAY - 1);
  localparam logic [PH_W-1:0] LD_DISC = PH_W'(LAT_DISC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_CORR, S_SDE, S_PAY, S_ACC, S_DISC, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [PH_W-1:0]   phase, phase_nxt;
  logic [STEP_W-1:0] steps_q, steps_nxt, step_nxt;
  logic [PATH_W-1:0] paths_q, paths_nxt, path_nxt;
  logic              err_nxt, clr_nxt, tc;

  assign tc = (phase == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      phase    <= '0;
      steps_q  <= '0;
      paths_q  <= '0;
      step_idx <= '0;
      path_idx <= '0;
      en_pg    <= 1'b0;
      en_corr  <= 1'b0;
      en_sde   <= 1'b0;
      sel_init <= 1'b0;
      en_pay   <= 1'b0;
      en_acc   <= 1'b0;
      acc_clr  <= 1'b0;
      en_disc  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      steps_q  <= steps_nxt;
      paths_q  <= paths_nxt;
      step_idx <= step_nxt;
      path_idx <= path_nxt;
      en_pg    <= (state_nxt == S_GEN);
      en_corr  <= (state_nxt == S_CORR);
      en_sde   <= (state_nxt == S_SDE);
      sel_init <= (state_nxt inside {S_GEN, S_CORR, S_SDE}) && (step_nxt == '0);
      en_pay   <= (state_nxt == S_PAY);
      en_acc   <= (state_nxt == S_ACC);
      acc_clr  <= clr_nxt;
      en_disc  <= (state_nxt == S_DISC);
      busy     <= (state_nxt != S_IDLE);
      done     <= (state_nxt == S_DONE);
      err      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = tc ? '0 : phase - 1'b1;
    steps_nxt = steps_q;
    paths_nxt = paths_q;
    step_nxt  = step_idx;
    path_nxt  = path_idx;
    err_nxt   = 1'b0;
    clr_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        phase_nxt = '0;
        if (start && !abort) begin
          steps_nxt = n_steps;
          paths_nxt = n_paths;
          if (n_steps == '0 || n_paths == '0) begin
            state_nxt = S_DONE;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = S_GEN;
            phase_nxt = LD_PG;
            step_nxt  = '0;
            path_nxt  = '0;
            clr_nxt   = 1'b1;
          end
        end
      end
      S_GEN:  if (tc) begin state_nxt = S_CORR; phase_nxt = LD_CORR; end
      S_CORR: if (tc) begin state_nxt = S_SDE;  phase_nxt = LD_SDE;  end
      S_SDE: begin
        // steps_q is never 0 here, so the subtraction cannot underflow
        if (tc) begin
          if (step_idx != steps_q - STEP_W'(1)) begin
            step_nxt  = step_idx + 1'b1;
            state_nxt = S_GEN;
            phase_nxt = LD_PG;
          end else begin
            state_nxt = S_PAY;
            phase_nxt = LD_PAY;
          end
        end
      end
      S_PAY:  if (tc) begin state_nxt = S_ACC; phase_nxt = '0; end
      S_ACC: begin
        if (path_idx != paths_q - PATH_W'(1)) begin
          path_nxt  = path_idx + 1'b1;
          step_nxt  = '0;
          state_nxt = S_GEN;
          phase_nxt = LD_PG;
        end else begin
          state_nxt = S_DISC;
          phase_nxt = LD_DISC;
        end
      end
      S_DISC: if (tc) begin state_nxt = S_DONE; phase_nxt = '0; end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
      phase_nxt = '0;
      step_nxt  = step_idx;
      path_nxt  = path_idx;
      err_nxt   = 1'b0;
      clr_nxt   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_path_scheduler.sv
// Scoreboard bench for mc_path_scheduler: expected per-cycle output codes and done
// latencies are queued at stimulus time and checked by a forked monitor.
module tb_mc_path_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] n_steps = '0;
  logic [31:0] n_paths = '0;

  logic a_pg, a_corr, a_sde, a_sel, a_pay, a_acc, a_clr, a_disc, a_busy, a_done, a_err;
  logic b_pg, b_corr, b_sde, b_sel, b_pay, b_acc, b_clr, b_disc, b_busy, b_done, b_err;
  logic [15:0] a_step, b_step;
  logic [31:0] a_path, b_path;

  logic m_pg, m_corr, m_sde, m_sel, m_pay, m_acc, m_clr, m_disc, m_busy, m_done, m_err;
  logic [15:0] m_step;
  logic [31:0] m_path;
  logic        sel_b = 1'b0;

  int exp_trace[$];
  int exp_lat[$];
  int tick = 0;
  int t_start = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mc_path_scheduler u_dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .n_steps(n_steps), .n_paths(n_paths),
    .en_pg(a_pg), .en_corr(a_corr), .en_sde(a_sde), .sel_init(a_sel),
    .en_pay(a_pay), .en_acc(a_acc), .acc_clr(a_clr), .en_disc(a_disc),
    .step_idx(a_step), .path_idx(a_path), .busy(a_busy), .done(a_done), .err(a_err)
  );

  mc_path_scheduler #(.LAT_SDE(3)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .n_steps(n_steps), .n_paths(n_paths),
    .en_pg(b_pg), .en_corr(b_corr), .en_sde(b_sde), .sel_init(b_sel),
    .en_pay(b_pay), .en_acc(b_acc), .acc_clr(b_clr), .en_disc(b_disc),
    .step_idx(b_step), .path_idx(b_path), .busy(b_busy), .done(b_done), .err(b_err)
  );

  always_comb begin
    if (sel_b) begin
      {m_pg, m_corr, m_sde, m_sel, m_pay, m_acc} = {b_pg, b_corr, b_sde, b_sel, b_pay, b_acc};
      {m_clr, m_disc, m_busy, m_done, m_err}     = {b_clr, b_disc, b_busy, b_done, b_err};
      m_step = b_step;
      m_path = b_path;
    end else begin
      {m_pg, m_corr, m_sde, m_sel, m_pay, m_acc} = {a_pg, a_corr, a_sde, a_sel, a_pay, a_acc};
      {m_clr, m_disc, m_busy, m_done, m_err}     = {a_clr, a_disc, a_busy, a_done, a_err};
      m_step = a_step;
      m_path = a_path;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // code = {err, acc_clr, sel_init, op}; op 1..7 = pg,corr,sde,pay,acc,disc,done; 15 = several high
  function automatic int cur_code();
    int op;
    int nhi;
    nhi = int'(m_pg) + int'(m_corr) + int'(m_sde) + int'(m_pay) + int'(m_acc)
        + int'(m_disc) + int'(m_done);
    op = 0;
    if (m_pg)   op = 1;
    if (m_corr) op = 2;
    if (m_sde)  op = 3;
    if (m_pay)  op = 4;
    if (m_acc)  op = 5;
    if (m_disc) op = 6;
    if (m_done) op = 7;
    if (nhi > 1) op = 15;
    return (int'(m_err) << 6) | (int'(m_clr) << 5) | (int'(m_sel) << 4) | op;
  endfunction

  task automatic monitor_loop();
    int code;
    forever begin
      @(negedge clk);
      tick++;
      code = cur_code();
      if (code != 0) begin
        if (exp_trace.size() == 0) check("unexpected_output", code, 0);
        else check($sformatf("trace_cycle_%0d", tick - t_start), code, exp_trace.pop_front());
      end
      if (m_done) begin
        if (exp_lat.size() == 0) check("unexpected_done", m_done, 0);
        else check("done_latency", tick - t_start, exp_lat.pop_front());
      end
    end
  endtask

  // Expected schedule for LAT_PG=LAT_CORR=LAT_PAY=1, LAT_DISC=4; only the first `limit` codes are queued.
  task automatic push_run(input int ns, input int np, input int lsde, input int limit, input int lat);
    int q[$];
    int sel, clr;
    for (int p = 0; p < np; p++) begin
      for (int s = 0; s < ns; s++) begin
        sel = (s == 0) ? 16 : 0;
        clr = (p == 0 && s == 0) ? 32 : 0;
        q.push_back(clr | sel | 1);
        q.push_back(sel | 2);
        for (int k = 0; k < lsde; k++) q.push_back(sel | 3);
      end
      q.push_back(4);
      q.push_back(5);
    end
    for (int k = 0; k < 4; k++) q.push_back(6);
    q.push_back(7);
    for (int i = 0; i < q.size() && i < limit; i++) exp_trace.push_back(q[i]);
    if (limit >= q.size()) exp_lat.push_back(lat);
  endtask

  task automatic do_start(input int ns, input int np);
    @(negedge clk);
    n_steps = 16'(ns);
    n_paths = 32'(np);
    start = 1'b1;
    @(posedge clk);
    t_start = tick;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (m_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, m_busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_empty(input string name);
    check({name, "_trace_left"}, exp_trace.size(), 0);
    check({name, "_done_left"}, exp_lat.size(), 0);
    exp_trace.delete();
    exp_lat.delete();
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    repeat (3) @(negedge clk);
    check("reset_outputs", {m_pg, m_corr, m_sde, m_sel, m_pay, m_acc, m_clr, m_disc, m_busy, m_done, m_err}, 0);
    check("reset_step", m_step, 0);
    check("reset_path", m_path, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 3 steps x 2 paths: done at 27, indices hold in IDLE
    push_run(3, 2, 1, 1000, 27);
    do_start(3, 2);
    wait_idle("r3x2", 100);
    check_empty("r3x2");
    check("hold_step", m_step, 2);
    check("hold_path", m_path, 1);

    // 1 step x 1 path: done at 10
    push_run(1, 1, 1, 1000, 10);
    do_start(1, 1);
    wait_idle("r1x1", 100);
    check_empty("r1x1");

    // LAT_SDE=3 instance, 2 steps x 1 path: done at 17
    sel_b = 1'b1;
    push_run(2, 1, 3, 1000, 17);
    do_start(2, 1);
    wait_idle("sde3", 100);
    check_empty("sde3");
    sel_b = 1'b0;

    // zero counts: done with err on the next cycle, nothing else
    exp_trace.push_back(7'h47);
    exp_lat.push_back(1);
    do_start(3, 0);
    wait_idle("np0", 20);
    check_empty("np0");
    exp_trace.push_back(7'h47);
    exp_lat.push_back(1);
    do_start(0, 2);
    wait_idle("ns0", 20);
    check_empty("ns0");

    // abort together with start in IDLE: start ignored
    @(negedge clk);
    n_steps = 16'd3;
    n_paths = 32'd2;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort_busy", m_busy, 0);
    repeat (3) @(negedge clk);

    // abort sampled at the end of cycle 14 (second path's SDE of step 0)
    push_run(3, 2, 1, 14, 0);
    do_start(3, 2);
    repeat (13) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_enables", {m_pg, m_corr, m_sde, m_pay, m_acc, m_disc, m_done, m_clr}, 0);
    check("abort_busy", m_busy, 0);
    repeat (40) @(negedge clk);
    check_empty("abort");
    push_run(3, 2, 1, 1000, 27);
    do_start(3, 2);
    wait_idle("after_abort", 100);
    check_empty("after_abort");

    // start while busy is ignored; reset during the second DISC cycle
    push_run(2, 1, 1, 9, 0);
    do_start(2, 1);
    n_steps = 16'd9;
    n_paths = 32'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_start_step", m_step, 1);
    check("busy_start_path", m_path, 0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_outputs", {m_pg, m_corr, m_sde, m_sel, m_pay, m_acc, m_clr, m_disc, m_busy, m_done, m_err}, 0);
    check("rst_mid_step", m_step, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check_empty("rst_mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
